// File: rtl/pdp8_memory_ctrl.sv
// Unified 4K x 12 PDP-8 main memory: power-up clear, program load, then
// dual read ports (fetch, operand) plus one operand write port with write-first forwarding.
module pdp8_memory_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_rd_valid,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_done,
    output logic                  mem_ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Single array write port, owned by whichever phase the controller is in
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
            end
            ST_LOAD: begin
                mem_we    = ld_valid;
                mem_waddr = ld_addr;
                mem_wdata = ld_data;
            end
            ST_RUN: begin
                mem_we    = exec_wr_req;
                mem_waddr = exec_wr_addr;
                mem_wdata = exec_wr_data;
            end
            default: ;
        endcase
    end

    // Storage array is never reset; CLEAR is the only thing that zeroes it
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Phase sequencing and registered read ports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;
            clr_cnt       <= '0;
            ifu_rd_data   <= '0;
            ifu_rd_valid  <= 1'b0;
            exec_rd_data  <= '0;
            exec_rd_valid <= 1'b0;
            mem_ready     <= 1'b0;
        end else begin
            ifu_rd_valid  <= 1'b0;
            exec_rd_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    if (&clr_cnt) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ld_done) begin
                        state     <= ST_RUN;
                        mem_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A same-edge write to the read address wins over the stored word
                    if (ifu_rd_req) begin
                        ifu_rd_valid <= 1'b1;
                        ifu_rd_data  <= (exec_wr_req && (exec_wr_addr == ifu_rd_addr))
                                        ? exec_wr_data : mem[ifu_rd_addr];
                    end
                    if (exec_rd_req) begin
                        exec_rd_valid <= 1'b1;
                        exec_rd_data  <= (exec_wr_req && (exec_wr_addr == exec_rd_addr))
                                         ? exec_wr_data : mem[exec_rd_addr];
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_pdp8_memory_ctrl.sv
// Scoreboard bench for pdp8_memory_ctrl: one instance with power-up clear,
// one with CLEAR_ON_RESET = 0.
module tb_pdp8_memory_ctrl;

    typedef struct {
        logic [11:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    exp_t qa_ifu[$];
    exp_t qa_exe[$];
    exp_t qb_ifu[$];
    exp_t qb_exe[$];

    logic        a_rst, a_ifu_req, a_ifu_valid, a_exe_req, a_exe_valid, a_wr_req;
    logic        a_ld_valid, a_ld_done, a_ready;
    logic [11:0] a_ifu_addr, a_ifu_data, a_exe_addr, a_exe_data, a_wr_addr, a_wr_data;
    logic [11:0] a_ld_addr, a_ld_data;

    logic        b_rst, b_ifu_req, b_ifu_valid, b_exe_req, b_exe_valid, b_wr_req;
    logic        b_ld_valid, b_ld_done, b_ready;
    logic [11:0] b_ifu_addr, b_ifu_data, b_exe_addr, b_exe_data, b_wr_addr, b_wr_data;
    logic [11:0] b_ld_addr, b_ld_data;

    pdp8_memory_ctrl dut_a (
        .clk(clk), .reset(a_rst),
        .ifu_rd_req(a_ifu_req), .ifu_rd_addr(a_ifu_addr),
        .ifu_rd_data(a_ifu_data), .ifu_rd_valid(a_ifu_valid),
        .exec_rd_req(a_exe_req), .exec_rd_addr(a_exe_addr),
        .exec_rd_data(a_exe_data), .exec_rd_valid(a_exe_valid),
        .exec_wr_req(a_wr_req), .exec_wr_addr(a_wr_addr), .exec_wr_data(a_wr_data),
        .ld_valid(a_ld_valid), .ld_addr(a_ld_addr), .ld_data(a_ld_data),
        .ld_done(a_ld_done), .mem_ready(a_ready)
    );

    pdp8_memory_ctrl #(.CLEAR_ON_RESET(1'b0)) dut_b (
        .clk(clk), .reset(b_rst),
        .ifu_rd_req(b_ifu_req), .ifu_rd_addr(b_ifu_addr),
        .ifu_rd_data(b_ifu_data), .ifu_rd_valid(b_ifu_valid),
        .exec_rd_req(b_exe_req), .exec_rd_addr(b_exe_addr),
        .exec_rd_data(b_exe_data), .exec_rd_valid(b_exe_valid),
        .exec_wr_req(b_wr_req), .exec_wr_addr(b_wr_addr), .exec_wr_data(b_wr_data),
        .ld_valid(b_ld_valid), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
        .ld_done(b_ld_done), .mem_ready(b_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0o expected %0o (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge, then drop all single-cycle strobes
    task automatic step();
        @(posedge clk);
        #1;
        a_ifu_req = 1'b0; a_exe_req = 1'b0; a_wr_req = 1'b0; a_ld_valid = 1'b0;
        b_ifu_req = 1'b0; b_exe_req = 1'b0; b_wr_req = 1'b0; b_ld_valid = 1'b0;
    endtask

    task automatic a_ifu(input logic [11:0] addr, input logic [11:0] exp);
        a_ifu_req = 1'b1; a_ifu_addr = addr;
        qa_ifu.push_back('{exp, cyc + 1});
    endtask

    task automatic a_exe(input logic [11:0] addr, input logic [11:0] exp);
        a_exe_req = 1'b1; a_exe_addr = addr;
        qa_exe.push_back('{exp, cyc + 1});
    endtask

    task automatic a_wr(input logic [11:0] addr, input logic [11:0] data);
        a_wr_req = 1'b1; a_wr_addr = addr; a_wr_data = data;
    endtask

    task automatic a_load(input logic [11:0] addr, input logic [11:0] data);
        a_ld_valid = 1'b1; a_ld_addr = addr; a_ld_data = data;
    endtask

    task automatic a_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(a_ready), 32'd0);
        check({tag, "_ifu_data"}, 32'(a_ifu_data), 32'd0);
        check({tag, "_exe_data"}, 32'(a_exe_data), 32'd0);
        check({tag, "_ifu_valid"}, 32'(a_ifu_valid), 32'd0);
        check({tag, "_exe_valid"}, 32'(a_exe_valid), 32'd0);
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (a_ifu_valid) begin
            if (qa_ifu.size() == 0) check("a_ifu_spurious_valid", 32'd1, 32'd0);
            else begin
                e = qa_ifu.pop_front();
                check("a_ifu_data", 32'(a_ifu_data), 32'(e.data));
                check("a_ifu_latency", 32'(cyc), 32'(e.due));
            end
        end
        if (a_exe_valid) begin
            if (qa_exe.size() == 0) check("a_exe_spurious_valid", 32'd1, 32'd0);
            else begin
                e = qa_exe.pop_front();
                check("a_exe_data", 32'(a_exe_data), 32'(e.data));
                check("a_exe_latency", 32'(cyc), 32'(e.due));
            end
        end
        if (b_ifu_valid) begin
            if (qb_ifu.size() == 0) check("b_ifu_spurious_valid", 32'd1, 32'd0);
            else begin
                e = qb_ifu.pop_front();
                check("b_ifu_data", 32'(b_ifu_data), 32'(e.data));
                check("b_ifu_latency", 32'(cyc), 32'(e.due));
            end
        end
        if (b_exe_valid) begin
            if (qb_exe.size() == 0) check("b_exe_spurious_valid", 32'd1, 32'd0);
            else begin
                e = qb_exe.pop_front();
                check("b_exe_data", 32'(b_exe_data), 32'(e.data));
                check("b_exe_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_ifu_req = 1'b0; a_exe_req = 1'b0; a_wr_req = 1'b0; a_ld_valid = 1'b0; a_ld_done = 1'b0;
        b_ifu_req = 1'b0; b_exe_req = 1'b0; b_wr_req = 1'b0; b_ld_valid = 1'b0; b_ld_done = 1'b0;
        a_ifu_addr = '0; a_exe_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_ld_addr = '0; a_ld_data = '0;
        b_ifu_addr = '0; b_exe_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_ld_addr = '0; b_ld_data = '0;
        repeat (3) step();
        a_reset_vals("por");
        check("b_por_ready", 32'(b_ready), 32'd0);

        // Clear timing: ld_done held high so RUN follows the first LOAD cycle
        a_rst = 1'b0; a_ld_done = 1'b1;
        repeat (100) step();
        check("clear_ready_early", 32'(a_ready), 32'd0);
        repeat (3899) step();
        a_wr(12'o0010, 12'o7777);
        step();
        repeat (95) step();
        check("clear_ready_last", 32'(a_ready), 32'd0);
        step();
        check("load_ready", 32'(a_ready), 32'd0);
        a_ifu_req = 1'b1; a_ifu_addr = 12'o0010;
        step();
        a_ld_done = 1'b0;
        check("run_ready_at_4097", 32'(a_ready), 32'd1);
        check("gated_ifu_valid", 32'(a_ifu_valid), 32'd0);
        step();
        check("ifu_data_before_first_read", 32'(a_ifu_data), 32'd0);
        a_ifu(12'o0000, 12'o0000); a_exe(12'o3777, 12'o0000);
        step();
        a_ifu(12'o7777, 12'o0000); a_exe(12'o0010, 12'o0000);
        step();
        step();

        // Load and fetch
        a_rst = 1'b1;
        step();
        step();
        a_reset_vals("rst2");
        a_rst = 1'b0;
        repeat (4100) step();
        check("load_hold_ready", 32'(a_ready), 32'd0);
        a_load(12'o0200, 12'o7200);
        step();
        a_load(12'o0201, 12'o1234);
        step();
        a_ld_done = 1'b1;
        step();
        a_ld_done = 1'b0;
        check("ready_after_ld_done", 32'(a_ready), 32'd1);
        a_ifu(12'o0200, 12'o7200);
        step();
        a_ifu(12'o0201, 12'o1234);
        step();
        step();
        check("ifu_data_hold", 32'(a_ifu_data), 32'o1234);
        check("ifu_valid_idle", 32'(a_ifu_valid), 32'd0);

        // Load port ignored in RUN
        a_load(12'o0200, 12'o1111); a_ld_done = 1'b1;
        step();
        a_ld_done = 1'b0;
        a_ifu(12'o0200, 12'o7200);
        step();
        step();

        // Write-first collision on both read ports
        a_wr(12'o0050, 12'o4321); a_exe(12'o0050, 12'o4321); a_ifu(12'o0050, 12'o4321);
        step();
        step();
        a_exe(12'o0050, 12'o4321);
        step();
        step();
        check("exe_data_hold", 32'(a_exe_data), 32'o4321);

        // All three ports active on distinct addresses
        a_wr(12'o0300, 12'o0123); a_ifu(12'o0200, 12'o7200); a_exe(12'o0201, 12'o1234);
        step();
        a_exe(12'o0300, 12'o0123); a_ifu(12'o0300, 12'o0123);
        step();
        step();

        // Reset from RUN is immediate; then reset mid-LOAD restarts the clear
        a_rst = 1'b1;
        #1;
        a_reset_vals("rst_run");
        step();
        a_rst = 1'b0;
        repeat (4100) step();
        a_load(12'o0100, 12'o5555);
        step();
        step();
        a_rst = 1'b1;
        step();
        a_reset_vals("rst_load");
        step();
        a_rst = 1'b0; a_ld_done = 1'b1;
        repeat (4096) step();
        check("reclear_ready_4096", 32'(a_ready), 32'd0);
        step();
        a_ld_done = 1'b0;
        check("reclear_ready_4097", 32'(a_ready), 32'd1);
        a_exe(12'o0100, 12'o0000); a_ifu(12'o0200, 12'o0000);
        step();
        step();

        // No-clear instance: LOAD on the first cycle, write plus done together
        b_rst = 1'b0;
        b_ld_valid = 1'b1; b_ld_addr = 12'o0001; b_ld_data = 12'o0777; b_ld_done = 1'b1;
        step();
        b_ld_done = 1'b0;
        check("b_ready_next_cycle", 32'(b_ready), 32'd1);
        b_ifu_req = 1'b1; b_ifu_addr = 12'o0001; qb_ifu.push_back('{12'o0777, cyc + 1});
        b_exe_req = 1'b1; b_exe_addr = 12'o0001; qb_exe.push_back('{12'o0777, cyc + 1});
        step();
        repeat (3) step();

        check("a_ifu_pending", 32'(qa_ifu.size()), 32'd0);
        check("a_exe_pending", 32'(qa_exe.size()), 32'd0);
        check("b_ifu_pending", 32'(qb_ifu.size()), 32'd0);
        check("b_exe_pending", 32'(qb_exe.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pdp8_memory_ctrl.md
Name: pdp8_memory_ctrl

Overview:
- Unified 4K x 12 main memory for the PDP-8 core. Sits directly downstream of the fetch/decode stage (instruction read port) and the execute stage (operand read and write ports).
- Provides a power-up clear sequence and a program-load port before normal operation.
- Serves both stages with a registered 1-cycle read latency and write-first forwarding.

Parameters:
ADDR_WIDTH, 12, address width; memory depth = 2**ADDR_WIDTH words
DATA_WIDTH, 12, word width
CLEAR_ON_RESET, 1, 1 = zero all locations after reset; 0 = skip directly to LOAD

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
ifu_rd_req  input  1  instruction fetch read request
ifu_rd_addr  input  ADDR_WIDTH  fetch address
ifu_rd_data  output  DATA_WIDTH  fetched word
ifu_rd_valid  output  1  ifu_rd_data valid this cycle
exec_rd_req  input  1  operand read request
exec_rd_addr  input  ADDR_WIDTH  operand read address
exec_rd_data  output  DATA_WIDTH  operand read word
exec_rd_valid  output  1  exec_rd_data valid this cycle
exec_wr_req  input  1  operand write request
exec_wr_addr  input  ADDR_WIDTH  write address
exec_wr_data  input  DATA_WIDTH  write data
ld_valid  input  1  program-load write strobe
ld_addr  input  ADDR_WIDTH  load address
ld_data  input  DATA_WIDTH  load data
ld_done  input  1  end of program load
mem_ready  output  1  high only in RUN

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: ifu_rd_data = 0, exec_rd_data = 0, both valids = 0, mem_ready = 0, clear counter = 0.
  - FSM state after reset: CLEAR if CLEAR_ON_RESET = 1, otherwise LOAD.
  - Array contents are not reset directly; they are cleared only by the CLEAR state.
- FSM states: CLEAR -> LOAD -> RUN; no other transitions except reset.
- CLEAR:
  - Each cycle write 0 to location clr_cnt, then increment clr_cnt.
  - After writing location 2**ADDR_WIDTH-1 (4096 cycles at default), go to LOAD.
  - clr_cnt then wraps to 0.
- LOAD:
  - ld_valid = 1: write ld_data to ld_addr at the clock edge.
  - ld_done = 1: go to RUN next cycle.
  - ld_valid and ld_done in the same cycle: the write is performed, then the transition.
- RUN:
  - mem_ready = 1.
  - ld_valid and ld_done are ignored.
- Read timing (RUN only):
  - A request sampled at edge N drives *_rd_data and *_rd_valid = 1 during cycle N+1.
  - Valid is a single-cycle pulse per request; back-to-back requests give back-to-back valids.
  - With no request, data holds its last value and valid = 0.
- Write timing (RUN only): exec_wr_req commits exec_wr_data at the edge it is sampled.
- Collision (write-first): same-cycle exec_wr_req and a read on either port to the same address returns exec_wr_data, not the old contents.
- Port independence: ifu read, exec read and exec write may all occur in the same cycle to any addresses.
- Requests outside RUN: ignored (no write, valids stay 0, data outputs hold).
- Reset mid-operation (any state, including mid-CLEAR or mid-LOAD): immediately return to reset values. With CLEAR_ON_RESET = 1 the clear sequence restarts from address 0.
- Arithmetic: addresses are used unsigned at full width, with no wrap or offset logic. Data is stored verbatim, truncated to DATA_WIDTH.

Test Plan:
- Clear: reset, CLEAR_ON_RESET = 1, hold ld_done = 0 → mem_ready = 0 through CLEAR and LOAD. LOAD is reached exactly 4096 cycles after reset release. After ld_done, reads of 0o0000, 0o3777 and 0o7777 return 0.
- Load and fetch: in LOAD write 0o7200 @0o0200 and 0o1234 @0o0201, then ld_done. In RUN, ifu_rd_req @0o0200 then @0o0201 on consecutive cycles → ifu_rd_data = 0o7200 then 0o1234, ifu_rd_valid high for 2 consecutive cycles starting 1 cycle after the first request.
- Write-first collision: in RUN, same cycle exec_wr_req @0o0050 data 0o4321, exec_rd_req @0o0050 and ifu_rd_req @0o0050 → next cycle both data outputs = 0o4321 with both valids = 1. A later read also returns 0o4321.
- Gated requests: exec_wr_req @0o0010 data 0o7777 during CLEAR and ifu_rd_req during LOAD → no valid pulses. After RUN, 0o0010 reads 0, and ifu_rd_data stays 0 until the first RUN read.
- Reset mid-load: load 0o5555 @0o0100, assert reset for 2 cycles mid-LOAD → outputs return to reset values and CLEAR restarts. After the new ld_done, 0o0100 reads 0.
- CLEAR_ON_RESET = 0: after reset the FSM is in LOAD on the first cycle. ld_valid and ld_done together @0o0001 data 0o0777 → mem_ready = 1 next cycle, and a read of 0o0001 returns 0o0777.
